// File: rtl/ff_pipe_bank.sv
// ff_pipe_bank: multi-lane register pipeline with a shared valid/ready handshake.
// Each stage holds a valid bit and a full multi-lane data word. Bubbles collapse.
// A stage accepts a beat when it is empty or when the stage after it is accepting.
// A synchronous clear and an asynchronous reset both empty every stage.
// Both also load RESET_VAL into every lane.
module ff_pipe_bank #(
    parameter int N_LANE = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int DW = N_LANE * WIDTH,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_arst_n,
    input  logic              i_srst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DW-1:0]     i_data,
    input  logic [N_LANE-1:0] i_lane_en,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DW-1:0]     o_data,
    output logic [CW-1:0]     o_count
);

    localparam logic [DW-1:0] RST_WORD = {N_LANE{RESET_VAL}};

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [DW-1:0]    d_q [DEPTH];
    logic [DW-1:0]    d_d [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [DEPTH-1:0] rdy;

    // Lanes whose enable is low are replaced by RESET_VAL.
    function automatic logic [DW-1:0] mask_lanes(input logic [DW-1:0] data,
                                                 input logic [N_LANE-1:0] en);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < N_LANE; k++) begin
            r[k*WIDTH +: WIDTH] = en[k] ? data[k*WIDTH +: WIDTH] : RESET_VAL;
        end
        return r;
    endfunction

    // Number of set valid bits. The result fits in CW bits by construction.
    function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    // Stage s can accept when i_ready is high or any stage from s to the output is empty.
    // This is the closed form of the ripple ~v[s] | rdy[s+1]. It has no self-referencing chain.
    always_comb begin
        logic full_tail;
        full_tail = 1'b1;
        rdy       = '0;
        for (int s = DEPTH - 1; s >= 0; s--) begin
            full_tail = full_tail & v_q[s];
            rdy[s]    = i_ready | ~full_tail;
        end
    end

    // Next-state logic. The clear wins over every transfer.
    // A stalled stage keeps its own contents.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (i_srst) begin
            v_d = '0;
            for (int s = 0; s < DEPTH; s++) begin
                d_d[s] = RST_WORD;
            end
        end else begin
            if (rdy[0]) begin
                v_d[0] = i_valid;
                if (i_valid) begin
                    d_d[0] = mask_lanes(i_data, i_lane_en);
                end
            end
            for (int s = 1; s < DEPTH; s++) begin
                if (rdy[s]) begin
                    v_d[s] = v_q[s-1];
                    if (v_q[s-1]) begin
                        d_d[s] = d_q[s-1];
                    end
                end
            end
        end
        count_d = popcount(v_d);
    end

    // Stage registers and occupancy count. The async reset empties the pipe immediately.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            v_q     <= '0;
            count_q <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                d_q[s] <= RST_WORD;
            end
        end else begin
            v_q     <= v_d;
            d_q     <= d_d;
            count_q <= count_d;
        end
    end

    assign o_ready = rdy[0] & ~i_srst & i_arst_n;
    assign o_valid = v_q[DEPTH-1];
    assign o_data  = d_q[DEPTH-1];
    assign o_count = count_q;

endmodule

// File: tb/tb_ff_pipe_bank.sv
// Scoreboard bench for ff_pipe_bank (4 lanes x 8 bits, depth 3, reset value 0).
module tb_ff_pipe_bank;

    logic        clk;
    logic        i_arst_n;
    logic        i_srst;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_data;
    logic [3:0]  i_lane_en;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_data;
    logic [1:0]  o_count;

    int          total;
    int          bad;
    logic [31:0] q[$];

    ff_pipe_bank #(
        .N_LANE(4),
        .WIDTH(8),
        .DEPTH(3),
        .RESET_VAL(8'h00)
    ) dut (
        .i_clk(clk),
        .i_arst_n(i_arst_n),
        .i_srst(i_srst),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_data(i_data),
        .i_lane_en(i_lane_en),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_data(o_data),
        .o_count(o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Holds a beat on the input until it is accepted. The expected output is pushed on acceptance.
    task automatic send(input logic [31:0] data, input logic [3:0] en,
                        input logic [31:0] exp, input int budget);
        bit done;
        done      = 1'b0;
        i_valid   = 1'b1;
        i_data    = data;
        i_lane_en = en;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            if (o_ready) begin
                q.push_back(exp);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout: beat %h got no o_ready within %0d cycles, expected accept", data, budget);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int c;
        c = 0;
        while (q.size() != 0 && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk(name, 32'(q.size()), 32'd0);
    endtask

    // Monitor: compares each beat the DUT hands downstream against the scoreboard head.
    always @(negedge clk) begin
        if (!i_arst_n || i_srst) begin
            q.delete();
        end else if (o_valid && i_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got %h, expected no output", o_data);
            end else begin
                chk("beat_data", o_data, q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        total     = 0;
        bad       = 0;
        i_arst_n  = 1'b0;
        i_srst    = 1'b0;
        i_valid   = 1'b1;
        i_data    = 32'hFFFF_FFFF;
        i_lane_en = 4'hF;
        i_ready   = 1'b1;

        // Reset held with a valid input present
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_data", o_data, 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd0);
        i_arst_n = 1'b1;
        i_valid  = 1'b0;
        #1;
        chk("rst_ready_release", 32'(o_ready), 32'd1);
        @(posedge clk);
        #1;

        // Streaming with latency check on the first beat
        fork
            begin
                for (int k = 1; k <= 5; k++) send(32'(k), 4'hF, 32'(k), 4);
            end
            begin
                @(posedge clk); #1;
                chk("lat_edge1_valid", 32'(o_valid), 32'd0);
                @(posedge clk); #1;
                chk("lat_edge2_valid", 32'(o_valid), 32'd0);
                @(posedge clk); #1;
                chk("lat_edge3_valid", 32'(o_valid), 32'd1);
                chk("lat_edge3_data", o_data, 32'd1);
            end
        join
        wait_drain("stream_drain", 10);

        // Lane masking
        send(32'hDDCC_BBAA, 4'b0101, 32'h00CC_00AA, 4);
        send(32'hDDCC_BBAA, 4'b1010, 32'hDD00_BB00, 4);
        wait_drain("mask_drain", 10);

        // Backpressure: fill, then accept and emit on the same edge, then drain
        i_ready = 1'b0;
        send(32'hA1, 4'hF, 32'hA1, 2);
        send(32'hA2, 4'hF, 32'hA2, 2);
        send(32'hA3, 4'hF, 32'hA3, 2);
        i_valid   = 1'b1;
        i_data    = 32'hA4;
        i_lane_en = 4'hF;
        #1;
        chk("bp_ready_full", 32'(o_ready), 32'd0);
        chk("bp_count_full", 32'(o_count), 32'd3);
        chk("bp_valid_full", 32'(o_valid), 32'd1);
        chk("bp_data_hold", o_data, 32'hA1);
        i_ready = 1'b1;
        send(32'hA4, 4'hF, 32'hA4, 2);
        chk("bp_count_flow", 32'(o_count), 32'd3);
        @(posedge clk); #1;
        chk("bp_count_2", 32'(o_count), 32'd2);
        @(posedge clk); #1;
        chk("bp_count_1", 32'(o_count), 32'd1);
        @(posedge clk); #1;
        chk("bp_count_0", 32'(o_count), 32'd0);
        wait_drain("bp_drain", 4);

        // Synchronous clear on a full pipe with both handshakes active
        i_ready = 1'b0;
        send(32'hB1, 4'hF, 32'hB1, 2);
        send(32'hB2, 4'hF, 32'hB2, 2);
        send(32'hB3, 4'hF, 32'hB3, 2);
        i_srst  = 1'b1;
        i_valid = 1'b1;
        i_data  = 32'h55;
        i_ready = 1'b1;
        #1;
        chk("sc_ready", 32'(o_ready), 32'd0);
        @(posedge clk); #1;
        i_srst  = 1'b0;
        i_valid = 1'b0;
        chk("sc_valid", 32'(o_valid), 32'd0);
        chk("sc_count", 32'(o_count), 32'd0);
        chk("sc_data", o_data, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("sc_no_beat", 32'(o_valid), 32'd0);

        // Asynchronous reset between edges with two beats in flight
        i_ready = 1'b0;
        send(32'hC1, 4'hF, 32'hC1, 2);
        send(32'hC2, 4'hF, 32'hC2, 2);
        @(posedge clk); #1;
        chk("ar_valid_before", 32'(o_valid), 32'd1);
        #2;
        i_arst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(o_valid), 32'd0);
        chk("ar_count", 32'(o_count), 32'd0);
        chk("ar_data", o_data, 32'd0);
        chk("ar_ready", 32'(o_ready), 32'd0);
        @(posedge clk); #1;
        i_arst_n = 1'b1;
        i_ready  = 1'b1;
        #1;
        chk("ar_ready_release", 32'(o_ready), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("ar_no_ghost", 32'(o_valid), 32'd0);

        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
